// File: rtl/stage2_execute.sv
// Execute stage behind stage1: single-cycle arith/logic ops plus an iterative
// shifter that holds busy high so stage1 keeps its shift request stable.
module stage2_execute #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             enable_ex,
    input  logic [WIDTH-1:0] aluin1,
    input  logic [WIDTH-1:0] aluin2,
    input  logic [2:0]       operation,
    input  logic [2:0]       opselect,
    input  logic             enable_arith,
    input  logic             enable_shift,
    input  logic [4:0]       shift_number,
    output logic [WIDTH-1:0] aluout,
    output logic             carry,
    output logic             valid_out,
    output logic             busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [5:0] STEP = 6'(SHIFT_STEP);

    state_t           state_q;
    logic [WIDTH-1:0] aluout_q;
    logic             carry_q;
    logic             valid_q;
    logic [WIDTH-1:0] shiftVal_q;
    logic [4:0]       remaining_q;
    logic [1:0]       shiftType_q;

    logic [WIDTH-1:0] arithOut_d;
    logic             arithCarry_d;
    logic [WIDTH-1:0] shiftVal_d;
    logic             shiftCarry_d;
    logic [WIDTH:0]   sum;
    logic [5:0]       stepAmt;
    logic [31:0]      rotAmt;
    logic [WIDTH-1:0] preLeft;
    logic [WIDTH-1:0] preRight;
    logic             lastStep;

    assign sum = {1'b0, aluin1} + {1'b0, aluin2};

    // opselect 101 is the load path and overrides the operation code.
    always_comb begin
        arithOut_d   = '0;
        arithCarry_d = 1'b0;
        if (opselect == 3'b101) begin
            arithOut_d = aluin2;
        end else begin
            case (operation)
                3'b000: {arithCarry_d, arithOut_d} = sum;
                3'b001: begin
                    arithOut_d   = aluin1 - aluin2;
                    arithCarry_d = (aluin1 < aluin2);
                end
                3'b010: arithOut_d = aluin1 & aluin2;
                3'b011: arithOut_d = aluin1 | aluin2;
                3'b100: arithOut_d = aluin1 ^ aluin2;
                3'b101: arithOut_d = ~aluin2;
                3'b110: arithOut_d = aluin2;
                default: arithOut_d = {{(WIDTH-1){1'b0}}, ($signed(aluin1) < $signed(aluin2))};
            endcase
        end
    end

    assign stepAmt  = ({1'b0, remaining_q} > STEP) ? STEP : {1'b0, remaining_q};
    assign lastStep = ({1'b0, remaining_q} <= STEP);
    assign rotAmt   = 32'(WIDTH) - 32'(stepAmt);
    // One position short of the full step, so the bit about to fall off sits at the edge.
    assign preLeft  = shiftVal_q << (stepAmt - 6'd1);
    assign preRight = shiftVal_q >> (stepAmt - 6'd1);

    always_comb begin
        shiftVal_d   = shiftVal_q;
        shiftCarry_d = 1'b0;
        case (shiftType_q)
            2'b00: begin
                shiftVal_d   = shiftVal_q << stepAmt;
                shiftCarry_d = preLeft[WIDTH-1];
            end
            2'b01: begin
                shiftVal_d   = shiftVal_q >> stepAmt;
                shiftCarry_d = preRight[0];
            end
            2'b10: begin
                shiftVal_d   = $signed(shiftVal_q) >>> stepAmt;
                shiftCarry_d = preRight[0];
            end
            default: begin
                shiftVal_d   = (shiftVal_q << stepAmt) | (shiftVal_q >> rotAmt);
                shiftCarry_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= IDLE;
            aluout_q    <= '0;
            carry_q     <= 1'b0;
            valid_q     <= 1'b0;
            shiftVal_q  <= '0;
            remaining_q <= '0;
            shiftType_q <= 2'b00;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable_ex) begin
                        if (enable_arith) begin
                            aluout_q <= arithOut_d;
                            carry_q  <= arithCarry_d;
                            valid_q  <= 1'b1;
                        end else if (enable_shift) begin
                            if (shift_number == 5'd0) begin
                                aluout_q <= aluin1;
                                carry_q  <= 1'b0;
                                valid_q  <= 1'b1;
                            end else begin
                                shiftVal_q  <= aluin1;
                                remaining_q <= shift_number;
                                shiftType_q <= operation[1:0];
                                state_q     <= SHIFT;
                            end
                        end
                    end
                end
                default: begin
                    if (enable_ex) begin
                        shiftVal_q  <= shiftVal_d;
                        remaining_q <= remaining_q - stepAmt[4:0];
                        if (lastStep) begin
                            aluout_q <= shiftVal_d;
                            carry_q  <= shiftCarry_d;
                            valid_q  <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign aluout    = aluout_q;
    assign carry     = carry_q;
    assign valid_out = valid_q;
    assign busy      = (state_q == SHIFT);

endmodule
